// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX feeder: launch FSM encoding and default byte width.
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_BUSY = 2'b01,
    WAIT_DONE = 2'b10
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host/transmitter-facing signal bundle of uart_tx_feeder.
// LEVEL and ALMOST_FULL exist only when UART_TX_FEEDER_LEVEL_EN is defined.
interface uart_tx_feeder_if
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16
);

  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_EN;
  logic                  FULL;
  logic                  EMPTY;
  logic                  OVERFLOW;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [$clog2(DEPTH):0] LEVEL;
  logic                   ALMOST_FULL;
`endif

  // Host and transmitter side: drives pushes and BUSY, observes status and launches.
  modport master (
    output WR_DATA, WR_EN, TX_BUSY,
    input  FULL, EMPTY, OVERFLOW, P_DATA, DATA_VALID
`ifdef UART_TX_FEEDER_LEVEL_EN
    , input LEVEL, ALMOST_FULL
`endif
  );

  // Feeder side.
  modport slave (
    input  WR_DATA, WR_EN, TX_BUSY,
    output FULL, EMPTY, OVERFLOW, P_DATA, DATA_VALID
`ifdef UART_TX_FEEDER_LEVEL_EN
    , output LEVEL, ALMOST_FULL
`endif
  );

endinterface

// File: rtl/uart_tx_feeder_mem.sv
// Circular byte store for uart_tx_feeder: array, wrapping pointers, occupancy count.
// The count output exists only when UART_TX_FEEDER_LEVEL_EN is defined.
module uart_tx_feeder_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        full,
  output logic                        empty
`ifdef UART_TX_FEEDER_LEVEL_EN
  , output logic [$clog2(DEPTH):0]    level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH; count nets out a simultaneous push and pop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
`ifdef UART_TX_FEEDER_LEVEL_EN
  assign level   = count;
`endif

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch controller feeding a UART TX FSM one frame at a time.
// Optional LEVEL/ALMOST_FULL outputs are enabled with UART_TX_FEEDER_LEVEL_EN.
module uart_tx_feeder
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12
) (
  input logic             CLK,
  input logic             RST,
  uart_tx_feeder_if.slave bus
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_THRESH > DEPTH) begin : g_param_check
    $error("uart_tx_feeder: DEPTH must be a power of two >= 2 and AF_THRESH <= DEPTH");
  end

  feeder_state_t         state;
  feeder_state_t         state_nxt;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  overflow;

  // FULL is the pre-edge view, so a push against a full FIFO is rejected even if a pop shares the edge.
  assign push = bus.WR_EN && !full;

  uart_tx_feeder_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push),
    .wr_data (bus.WR_DATA),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
`ifdef UART_TX_FEEDER_LEVEL_EN
    , .level (bus.LEVEL)
`endif
  );

  // Launch FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and pop decision: launch from IDLE only, then follow the frame through BUSY rise and fall.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.TX_BUSY) begin
          pop       = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (bus.TX_BUSY)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!bus.TX_BUSY) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Registered launch byte/pulse and the rejected-push flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data     <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (pop) p_data <= rd_data;
      data_valid <= pop;
      overflow   <= bus.WR_EN && full;
    end
  end

  assign bus.P_DATA     = p_data;
  assign bus.DATA_VALID = data_valid;
  assign bus.OVERFLOW   = overflow;
  assign bus.FULL       = full;
  assign bus.EMPTY      = empty;
`ifdef UART_TX_FEEDER_LEVEL_EN
  assign bus.ALMOST_FULL = (bus.LEVEL >= ($clog2(DEPTH) + 1)'(AF_THRESH));
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder against a queue-based reference model
// with an emulated transmitter (BUSY rises the cycle after each launch pulse).
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_feeder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DW-1:0] q [$];
  bit            inflight;
  bit            seen_busy;
  logic [DW-1:0] exp_pdata;
  bit            exp_dv;
  bit            exp_ovf;

  // Transmitter emulation
  int frame_cnt;
  int flen;
  bit stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dv"},    32'(bus.DATA_VALID), 32'(exp_dv));
    check({tag, ".pdata"}, 32'(bus.P_DATA),     32'(exp_pdata));
    check({tag, ".ovf"},   32'(bus.OVERFLOW),   32'(exp_ovf));
    check({tag, ".empty"}, 32'(bus.EMPTY),      32'(q.size() == 0));
    check({tag, ".full"},  32'(bus.FULL),       32'(q.size() == DEPTH));
`ifdef UART_TX_FEEDER_LEVEL_EN
    check({tag, ".level"}, 32'(bus.LEVEL),       32'(q.size()));
    check({tag, ".af"},    32'(bus.ALMOST_FULL), 32'(q.size() >= AF));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    inflight  = 1'b0;
    seen_busy = 1'b0;
    exp_pdata = '0;
    exp_dv    = 1'b0;
    exp_ovf   = 1'b0;
    frame_cnt = 0;
  endtask

  // One clock: drive inputs, advance the edge, update the model, check 1 time unit later.
  task automatic step(input string tag, input bit we, input logic [DW-1:0] d);
    bit busy;
    bit accept;
    bit launch;
    if (exp_dv) frame_cnt = flen;
    busy = stall || (frame_cnt > 0);
    if (frame_cnt > 0) frame_cnt--;
    bus.WR_EN   = we;
    bus.WR_DATA = d;
    bus.TX_BUSY = busy;
    @(posedge CLK);
    accept  = we && (q.size() < DEPTH);
    exp_ovf = we && !accept;
    launch  = !inflight && (q.size() > 0) && !busy;
    exp_dv  = launch;
    if (launch) begin
      exp_pdata = q.pop_front();
      inflight  = 1'b1;
      seen_busy = 1'b0;
    end else if (inflight) begin
      if (!seen_busy) begin
        if (busy) seen_busy = 1'b1;
      end else if (!busy) begin
        inflight = 1'b0;
      end
    end
    if (accept) q.push_back(d);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0);
  endtask

  initial begin
    logic [DW-1:0] b;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = '0;
    bus.TX_BUSY = 1'b0;
    stall = 1'b0;
    flen  = 10;
    model_reset();

    // Reset, then idle
    #12;
    check_outputs("reset");
    @(negedge CLK);
    RST = 1'b1;
    idle("post_reset", 3);

    // Single byte, 10-cycle frame
    flen = 10;
    step("push_a5", 1'b1, 8'hA5);
    step("launch_a5", 1'b0, '0);
    check("a5.dv_one_edge_after_push", 32'(bus.DATA_VALID), 32'd1);
    check("a5.pdata", 32'(bus.P_DATA), 32'hA5);
    idle("a5_frame", 15);

    // Three bytes queued under a held BUSY
    stall = 1'b1;
    step("push_01", 1'b1, 8'h01);
    step("push_02", 1'b1, 8'h02);
    step("push_03", 1'b1, 8'h03);
    idle("held_busy", 5);
    stall = 1'b0;
    flen  = 4;
    idle("drain_123", 30);

    // Fill to full, overflow, then drain in order across the pointer wrap
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, DW'($urandom_range(0, 254)));
    step("overflow_ff", 1'b1, 8'hFF);
    check("ovf.pulse", 32'(bus.OVERFLOW), 32'd1);
    step("after_ovf", 1'b0, '0);
    stall = 1'b0;
    for (int i = 0; i < 260; i++) begin
      flen = $urandom_range(1, 10);
      step("drain16", 1'b0, '0);
    end

    // Simultaneous push and pop at count 5, then climb through the almost-full threshold
    stall = 1'b1;
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, DW'($urandom));
    stall = 1'b0;
    flen  = 30;
    step("push_pop_5", 1'b1, 8'h55);
    check("pushpop.dv", 32'(bus.DATA_VALID), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 8; i++) step("climb_af", 1'b1, DW'($urandom));
    stall = 1'b0;
    flen  = 3;
    idle("drain_af", 120);

    // Reset during WAIT_DONE with 4 queued bytes
    flen = 3;
    step("rst_push", 1'b1, 8'h3C);
    step("rst_launch", 1'b0, '0);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) step("rst_queue", 1'b1, DW'($urandom));
    #1;
    RST = 1'b0;
    model_reset();
    stall = 1'b0;
    #1;
    check_outputs("async_reset");
    @(negedge CLK);
    RST = 1'b1;
    idle("no_launch_after_reset", 12);
    step("rst_new_push", 1'b1, 8'hC3);
    idle("rst_new_frame", 10);

    // Randomized traffic with occasional stalls
    for (int i = 0; i < 500; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      flen  = $urandom_range(1, 6);
      b     = DW'($urandom);
      step("random", ($urandom_range(0, 1) == 1), b);
    end
    stall = 1'b0;
    idle("final_drain", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and launch controller sitting directly upstream of the UART TX FSM/serializer. Accepts bytes from the host side into a circular FIFO and hands them one at a time to the transmitter via a single-cycle `DATA_VALID` pulse with `P_DATA`. Only launches when the transmitter reports not `BUSY`, and tracks each frame through BUSY rise and fall. Back-to-back frames therefore go out with no host involvement.

## Interface
- `DATA_WIDTH`, 8, byte width presented to the transmitter.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `AF_THRESH`, 12, almost-full level; used only with `UART_TX_FEEDER_LEVEL_EN`.

- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `WR_DATA`  in  DATA_WIDTH  byte to enqueue.
- `WR_EN`  in  1  push request, sampled each rising edge.
- `FULL`  out  1  count == DEPTH.
- `EMPTY`  out  1  count == 0.
- `OVERFLOW`  out  1  one-cycle pulse: push rejected.
- `TX_BUSY`  in  1  BUSY from the UART TX FSM.
- `P_DATA`  out  DATA_WIDTH  byte to transmitter, held until next launch.
- `DATA_VALID`  out  1  one-cycle launch pulse.
- `LEVEL`  out  $clog2(DEPTH)+1  current count (macro only).
- `ALMOST_FULL`  out  1  count ≥ AF_THRESH (macro only).

## Operation
- Storage: DEPTH×DATA_WIDTH array, write pointer, read pointer, count. Both pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0 naturally.
- Push:
  - `WR_EN`=1 and `FULL`=0 at an edge: write `WR_DATA` at wr_ptr, wr_ptr+1.
  - `WR_EN`=1 and `FULL`=1: data dropped, pointers unchanged, `OVERFLOW`=1 for the next cycle. This holds even if a pop occurs on the same edge, because `FULL` reflects the pre-edge count.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `EMPTY`=0 and `TX_BUSY`=0 at an edge, pop. `P_DATA` ← mem[rd_ptr], rd_ptr+1, `DATA_VALID` ← 1, go to WAIT_BUSY.
  - WAIT_BUSY: `DATA_VALID` ← 0 after its single cycle. Stay until `TX_BUSY`=1, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: stay while `TX_BUSY`=1. On `TX_BUSY`=0, go to IDLE.
- Count update per edge:
  - +1 for an accepted push.
  - −1 for a pop.
  - Unchanged when both occur.
- Empty FIFO with push on the same edge: no pop that edge; there is no bypass path.
- Outputs:
  - `FULL`, `EMPTY`, `LEVEL` and `ALMOST_FULL` decode the registered count.
  - `P_DATA`, `DATA_VALID` and `OVERFLOW` are registered.
- Reset (`RST`=0, asynchronous):
  - State → IDLE; pointers and count → 0.
  - `P_DATA`=0, `DATA_VALID`=0, `OVERFLOW`=0, `EMPTY`=1, `FULL`=0, `LEVEL`=0, `ALMOST_FULL`=0.
  - Memory contents are not reset.
  - A reset mid-frame drops all queued bytes; the in-flight frame belongs to the transmitter.

## Timing
- Push at edge k into an empty FIFO with the FSM in IDLE and `TX_BUSY`=0: `EMPTY` falls after k, and `DATA_VALID`=1 from edge k+1 to k+2.
- The transmitter samples `P_DATA` while `DATA_VALID`=1 and raises BUSY the next cycle.
- Launch-to-launch minimum: the pulse cycle, plus one or more WAIT_BUSY cycles, plus the frame length, plus one IDLE evaluation edge.
- `DATA_VALID` is never high on two consecutive cycles.
- `DATA_VALID` never asserts while `TX_BUSY`=1 at the evaluating edge.
- `OVERFLOW` pulses once per rejected push. Consecutive rejected pushes give consecutive high cycles.

## Configuration
- `UART_TX_FEEDER_LEVEL_EN` defined: the `LEVEL` and `ALMOST_FULL` ports exist and `AF_THRESH` is used.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `uart_tx_pkg`:
  - FSM state encoding: IDLE=2'b00, WAIT_BUSY=2'b01, WAIT_DONE=2'b10.
  - Default `DATA_WIDTH` constant.
- Sub-module `uart_tx_feeder_mem`: array, pointers, count, FULL/EMPTY.
- Top level: launch FSM, `P_DATA`/`DATA_VALID` registers and `OVERFLOW`.

## Test plan
- Reset then idle: `EMPTY`=1, `FULL`=0, `DATA_VALID`=0, `P_DATA`=0, `OVERFLOW`=0.
- Push 0xA5 with `TX_BUSY`=0:
  - `DATA_VALID` high exactly one cycle, one edge after the push, with `P_DATA`=0xA5.
  - Model BUSY rising one cycle later for 10 cycles, then falling.
  - Returns to IDLE; `EMPTY`=1.
- Push 0x01, 0x02, 0x03 back-to-back while `TX_BUSY`=1 held:
  - No `DATA_VALID` while BUSY is held.
  - After release, three launches in order 0x01, 0x02, 0x03, each waiting for its own BUSY rise and fall.
- Fill 16 entries with the transmitter stalled busy:
  - `FULL`=1.
  - 17th push (0xFF) gives an `OVERFLOW` pulse; the byte is never transmitted.
  - Pointer wrap is verified by a subsequent 16-byte drain in order.
- Pop and push on the same edge at count 5: count stays 5. With the macro: `LEVEL`=5, and `ALMOST_FULL` rises at count 12.
- Assert `RST` low while in WAIT_DONE with 4 queued bytes: immediate `EMPTY`=1 and state IDLE; no launch after release until a new push.
